mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one unified single-port memory between instruction fetch (read-only) and the data port
//  (read/write). One outstanding transaction at a time. Data has priority over fetch, with a
//  starvation guard for fetch. Sits between the core's fetch/LSU logic and the memory model or BRAM.
// PARAMETERS
//  ADDR_W        32  address width, both requesters and memory
//  DATA_W        32  data width; strobe width is DATA_W/8
//  STARVE_LIMIT  4   max consecutive data grants while fetch is pending; legal range 1..15
// PORTS
//  clk            in   1       clock; all state updates on posedge
//  rst            in   1       synchronous, active-high reset
//  if_req_valid   in   1       fetch request pending
//  if_req_ready   out  1       fetch request accepted this cycle
//  if_addr        in   ADDR_W  fetch address
//  if_rsp_valid   out  1       fetch read data valid (1-cycle pulse)
//  if_rdata       out  DATA_W  fetch read data
//  dm_req_valid   in   1       data request pending
//  dm_req_ready   out  1       data request accepted this cycle
//  dm_we          in   1       1=write, 0=read
//  dm_addr        in   ADDR_W  data address
//  dm_wdata       in   DATA_W  write data
//  dm_wstrb       in   DATA_W/8  byte enables (writes only)
//  dm_rsp_valid   out  1       data response pulse (read data or write ack)
//  dm_rdata       out  DATA_W  data read data
//  mem_req_valid  out  1       request to memory
//  mem_req_ready  in   1       memory accepts request
//  mem_we         out  1       memory write enable
//  mem_addr       out  ADDR_W  memory address
//  mem_wdata      out  DATA_W  memory write data
//  mem_wstrb      out  DATA_W/8  memory byte enables
//  mem_rsp_valid  in   1       memory response (reads and writes)
//  mem_rdata      in   DATA_W  memory read data
//  busy           out  1       state != IDLE
//  protocol_err   out  1       sticky: mem_rsp_valid seen outside WAIT
// BEHAVIOUR
//  - Reset: state=IDLE, owner=NONE, streak=0, protocol_err=0. All valid/ready outputs are 0.
//    All data/address outputs are 0.
//  - FSM IDLE -> ISSUE -> WAIT -> IDLE.
//  - IDLE: winner chosen combinationally. The winner's *_req_ready=1 in the same cycle as its valid.
//    addr/we/wdata/wstrb are captured into registers; the state moves to ISSUE. Nothing valid: stay.
//  - Arbitration, both valid: grant dm, unless streak==STARVE_LIMIT, then grant if.
//    Only one valid: grant it.
//  - Streak counter: +1 on a dm grant while if_req_valid=1. Cleared on an if grant, or in any
//    IDLE cycle with if_req_valid=0. Saturates at STARVE_LIMIT.
//  - ISSUE: mem_req_valid=1 with registered fields held stable until mem_req_ready=1, then go to WAIT.
//    Fetch drives mem_we=0 and mem_wstrb=0. Reads drive mem_wdata=0.
//  - WAIT: on mem_rsp_valid=1, owner's *_rsp_valid=1 in the same cycle and *_rdata=mem_rdata
//    (combinational route). Next state IDLE.
//    The non-owner's rsp_valid stays 0, and its rdata holds 0.
//  - A new request is accepted only in IDLE, so at most 1 transaction is outstanding.
//    Minimum accept->response latency: 2 cycles (mem_req_ready=1 in ISSUE, mem_rsp_valid the
//    next cycle). Back-to-back throughput: 1 transaction per 3 cycles.
//  - mem_rsp_valid in IDLE or ISSUE: ignored (no rsp pulse), sets protocol_err until rst.
//  - Reset mid-transaction: the transaction is dropped and no response is delivered.
//    A late mem_rsp_valid after reset sets protocol_err.
//  - Requesters must hold valid and fields until ready. The arbiter never asserts both readies
//    in one cycle.
// STRUCTURE
//  - mem_arb_pkg: typedef enum logic[1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} arb_state_t;
//    typedef enum logic[1:0] {OWN_NONE, OWN_IF, OWN_DM} arb_owner_t.
//  - Sub-module mem_arb_select: winner logic plus streak counter (inputs: both valids, idle;
//    outputs: grant_if, grant_dm). The top holds the FSM, request registers and response routing.
// TESTING
//  1. Fetch alone, addr 0x80000000, mem ready immediately, rsp rdata 0x00000013 next cycle ->
//     if_req_ready in cycle 0, mem_req_valid in cycle 1, if_rsp_valid with 0x00000013 in cycle 2.
//  2. Both valid every cycle, STARVE_LIMIT=4 -> grant order dm,dm,dm,dm,if,dm...; no fetch starves.
//  3. dm write addr 0x100, wdata 0xDEADBEEF, wstrb 4'b0011, mem_req_ready low 3 cycles ->
//     fields held stable and dm_rsp_valid once on ack; if_rsp_valid stays 0.
//  4. Pulse mem_rsp_valid while IDLE -> no rsp pulse, protocol_err=1 until rst.
//  5. Assert rst during WAIT -> next cycle busy=0, all valid/ready=0, and no rsp delivered to the
//     former owner.
//  6. Random valids plus random memory latency (0..5) -> each accepted request gets exactly one
//     response to the correct requester, in order.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory port arbiter: FSM states, transaction owner, streak width.
// Pure declarations; no timing or flow-control behaviour of its own.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_DM
    } arb_owner_t;

    // Wide enough for the largest legal starvation limit (15).
    localparam int STREAK_W = 4;

    function automatic logic [STREAK_W-1:0] sat_inc(
        input logic [STREAK_W-1:0] val,
        input logic [STREAK_W-1:0] limit
    );
        return (val >= limit) ? limit : val + 1'b1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and memory handshakes of the arbiter; slave is the arbiter's view,
// master is the view of the surrounding core + memory. No storage, zero latency.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_addr;
    logic              if_rsp_valid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req_valid;
    logic              dm_req_ready;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [STRB_W-1:0] dm_wstrb;
    logic              dm_rsp_valid;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req_valid, if_addr,
        output if_req_ready, if_rsp_valid, if_rdata,
        input  dm_req_valid, dm_we, dm_addr, dm_wdata, dm_wstrb,
        output dm_req_ready, dm_rsp_valid, dm_rdata,
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );

    modport master (
        output if_req_valid, if_addr,
        input  if_req_ready, if_rsp_valid, if_rdata,
        output dm_req_valid, dm_we, dm_addr, dm_wdata, dm_wstrb,
        input  dm_req_ready, dm_rsp_valid, dm_rdata,
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );

endinterface

// File: rtl/mem_arb_select.sv
// Picks fetch or data when the arbiter is idle: data first, fetch forced after STARVE_LIMIT data wins.
// Grants are combinational (same cycle as valid); the streak counter updates on the next edge.
module mem_arb_select
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_vld,
    input  logic dm_vld,
    input  logic idle,
    output logic grant_if,
    output logic grant_dm
);

    localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                starved;

    always_comb begin
        starved  = (streak_q == LIMIT);
        grant_if = 1'b0;
        grant_dm = 1'b0;
        streak_d = streak_q;

        if (idle) begin
            if (dm_vld && !(if_vld && starved)) begin
                grant_dm = 1'b1;
            end else if (if_vld) begin
                grant_if = 1'b1;
            end

            // Only data wins taken while fetch is waiting count towards starvation.
            if (grant_if || !if_vld) begin
                streak_d = '0;
            end else if (grant_dm) begin
                streak_d = sat_inc(streak_q, LIMIT);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data, one transaction in flight; accept->rsp >= 2 cycles.
// Requests wait in IDLE for a grant, ISSUE holds fields until mem_req_ready, responses are never stalled.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus,
    output logic              busy,
    output logic              protocol_err
);

    localparam int STRB_W = DATA_W / 8;

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              perr_q, perr_d;

    logic idle;
    logic issue;
    logic rsp_fire;
    logic grant_if;
    logic grant_dm;

    // Gating with rst keeps every handshake output quiet while reset is being applied.
    assign idle     = (state_q == ARB_IDLE) && !rst;
    assign issue    = (state_q == ARB_ISSUE) && !rst;
    assign rsp_fire = (state_q == ARB_WAIT) && bus.mem_rsp_valid && !rst;

    mem_arb_select #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_select (
        .clk     (clk),
        .rst     (rst),
        .if_vld  (bus.if_req_valid),
        .dm_vld  (bus.dm_req_valid),
        .idle    (idle),
        .grant_if(grant_if),
        .grant_dm(grant_dm)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;

        case (state_q)
            ARB_IDLE: begin
                if (grant_if) begin
                    state_d = ARB_ISSUE;
                    owner_d = OWN_IF;
                    we_d    = 1'b0;
                    addr_d  = bus.if_addr;
                    wdata_d = '0;
                    wstrb_d = '0;
                end else if (grant_dm) begin
                    state_d = ARB_ISSUE;
                    owner_d = OWN_DM;
                    we_d    = bus.dm_we;
                    addr_d  = bus.dm_addr;
                    wdata_d = bus.dm_we ? bus.dm_wdata : '0;
                    wstrb_d = bus.dm_we ? bus.dm_wstrb : '0;
                end
            end
            ARB_ISSUE: begin
                if (bus.mem_req_ready) begin
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (bus.mem_rsp_valid) begin
                    state_d = ARB_IDLE;
                    owner_d = OWN_NONE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                owner_d = OWN_NONE;
            end
        endcase

        perr_d = perr_q | (bus.mem_rsp_valid && (state_q != ARB_WAIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_NONE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            perr_q  <= perr_d;
        end
    end

    assign bus.if_req_ready = grant_if;
    assign bus.dm_req_ready = grant_dm;

    assign bus.mem_req_valid = issue;
    assign bus.mem_we        = issue & we_q;
    assign bus.mem_addr      = issue ? addr_q  : '0;
    assign bus.mem_wdata     = issue ? wdata_q : '0;
    assign bus.mem_wstrb     = issue ? wstrb_q : '0;

    // Only the owner sees the response; the other port's data stays at zero.
    assign bus.if_rsp_valid = rsp_fire && (owner_q == OWN_IF);
    assign bus.dm_rsp_valid = rsp_fire && (owner_q == OWN_DM);
    assign bus.if_rdata     = bus.if_rsp_valid ? bus.mem_rdata : '0;
    assign bus.dm_rdata     = bus.dm_rsp_valid ? bus.mem_rdata : '0;

    assign busy         = (state_q != ARB_IDLE);
    assign protocol_err = perr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed table of single transactions, arbitration/error/reset sequences, then random traffic.
// Memory model answers with rdata = addr ^ 0x80000013.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic protocol_err;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .busy        (busy),
        .protocol_err(protocol_err)
    );

    typedef struct {
        bit          dm;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          lat;
        bit          exp_we;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        bit          dm;
        logic [31:0] rdata;
    } exp_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    int          mm_cnt     = 0;
    int          mm_rsp_lat = 0;
    int          mm_rsp_cnt = 0;
    bit          mm_pend    = 1'b0;
    bit          mm_rand    = 1'b0;
    logic [31:0] mm_addr    = '0;

    function automatic logic [31:0] rsp_of(input logic [31:0] a);
        return a ^ 32'h8000_0013;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic mem_model();
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = '0;
        if (mm_pend) begin
            if (mm_rsp_cnt == 0) begin
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rdata     = rsp_of(mm_addr);
                mm_pend           = 1'b0;
            end else begin
                mm_rsp_cnt--;
            end
        end else if (bus.mem_req_valid) begin
            if (mm_cnt == 0) begin
                bus.mem_req_ready = 1'b1;
                mm_addr           = bus.mem_addr;
                mm_pend           = 1'b1;
                mm_rsp_cnt        = mm_rand ? int'($urandom_range(0, 2)) : mm_rsp_lat;
                mm_cnt            = mm_rand ? int'($urandom_range(0, 5)) : 0;
            end else begin
                mm_cnt--;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mem_model();
    endtask

    // Per-cycle scoreboard, sampled at the falling edge.
    task automatic mon();
        exp_t e;
        chk("both_ready", 32'(bus.if_req_ready & bus.dm_req_ready), 32'd0);
        if (bus.if_req_valid && bus.if_req_ready) sb.push_back('{1'b0, rsp_of(bus.if_addr)});
        if (bus.dm_req_valid && bus.dm_req_ready) sb.push_back('{1'b1, rsp_of(bus.dm_addr)});
        if (bus.if_rsp_valid || bus.dm_rsp_valid) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_port", 32'(bus.dm_rsp_valid), 32'(e.dm));
                chk("rsp_single", 32'(bus.if_rsp_valid & bus.dm_rsp_valid), 32'd0);
                chk("rsp_rdata", e.dm ? bus.dm_rdata : bus.if_rdata, e.rdata);
                chk("rsp_other_rdata", e.dm ? bus.if_rdata : bus.dm_rdata, 32'd0);
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        mm_cnt     = v.lat;
        mm_rsp_lat = 0;
        tick();
        if (v.dm) begin
            bus.dm_req_valid = 1'b1;
            bus.dm_we        = v.we;
            bus.dm_addr      = v.addr;
            bus.dm_wdata     = v.wdata;
            bus.dm_wstrb     = v.wstrb;
        end else begin
            bus.if_req_valid = 1'b1;
            bus.if_addr      = v.addr;
        end
        @(negedge clk);
        mon();
        chk($sformatf("v%0d_accept", idx), 32'(v.dm ? bus.dm_req_ready : bus.if_req_ready), 32'd1);
        for (int k = 1; k <= v.lat + 1; k++) begin
            tick();
            // Scramble the requester side so only the captured copy can reach memory.
            bus.if_req_valid = 1'b0;
            bus.dm_req_valid = 1'b0;
            bus.if_addr      = ~v.addr;
            bus.dm_addr      = ~v.addr;
            bus.dm_we        = ~v.we;
            bus.dm_wdata     = $urandom;
            bus.dm_wstrb     = ~v.wstrb;
            @(negedge clk);
            mon();
            chk($sformatf("v%0d_c%0d_mem_vld", idx, k), 32'(bus.mem_req_valid), 32'd1);
            chk($sformatf("v%0d_c%0d_mem_addr", idx, k), bus.mem_addr, v.addr);
            chk($sformatf("v%0d_c%0d_mem_we", idx, k), 32'(bus.mem_we), 32'(v.exp_we));
            chk($sformatf("v%0d_c%0d_mem_wdata", idx, k), bus.mem_wdata, v.exp_wdata);
            chk($sformatf("v%0d_c%0d_mem_wstrb", idx, k), 32'(bus.mem_wstrb), 32'(v.exp_wstrb));
        end
        tick();
        @(negedge clk);
        mon();
        chk($sformatf("v%0d_own_rsp", idx), 32'(v.dm ? bus.dm_rsp_valid : bus.if_rsp_valid), 32'd1);
        chk($sformatf("v%0d_other_rsp", idx), 32'(v.dm ? bus.if_rsp_valid : bus.dm_rsp_valid), 32'd0);
        chk($sformatf("v%0d_rdata", idx), v.dm ? bus.dm_rdata : bus.if_rdata, v.exp_rdata);
        tick();
        @(negedge clk);
        mon();
        chk($sformatf("v%0d_idle", idx), 32'(busy), 32'd0);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 60) begin
            tick();
            @(negedge clk);
            mon();
            n++;
        end
        chk(nm, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[5];
        bit   exp_g[10];
        bit   got_g[10];
        int   g;
        int   n;
        bit   if_hold;
        bit   dm_hold;

        vecs[0] = '{1'b0, 1'b0, 32'h8000_0000, 32'h0,         4'h0, 0, 1'b0, 32'h0,         4'h0, 32'h0000_0013};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'h3, 3, 1'b1, 32'hDEAD_BEEF, 4'h3, 32'h8000_0113};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_2000, 32'hFFFF_FFFF, 4'hF, 1, 1'b0, 32'h0,         4'h0, 32'h8000_2013};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_1234, 32'h0,         4'h0, 2, 1'b0, 32'h0,         4'h0, 32'h8000_1227};
        vecs[4] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 4'h8, 0, 1'b1, 32'h1234_5678, 4'h8, 32'h7FFF_FFEF};
        exp_g = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        rst               = 1'b1;
        bus.if_req_valid  = 1'b1;
        bus.if_addr       = 32'h0000_0040;
        bus.dm_req_valid  = 1'b0;
        bus.dm_we         = 1'b0;
        bus.dm_addr       = '0;
        bus.dm_wdata      = '0;
        bus.dm_wstrb      = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = '0;

        // Reset state, with a fetch request pending that must not be accepted.
        repeat (3) tick();
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_perr", 32'(protocol_err), 32'd0);
        chk("rst_if_ready", 32'(bus.if_req_ready), 32'd0);
        chk("rst_mem_vld", 32'(bus.mem_req_valid), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_if_rdata", bus.if_rdata, 32'd0);
        tick();
        bus.if_req_valid = 1'b0;
        rst              = 1'b0;
        tick();
        @(negedge clk);
        mon();
        chk("idle_no_req", 32'(busy), 32'd0);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Both requesters valid every cycle: four data grants, then fetch.
        g = 0;
        n = 0;
        while (g < 10 && n < 80) begin
            tick();
            bus.if_req_valid = 1'b1;
            bus.if_addr      = 32'h0000_4000;
            bus.dm_req_valid = 1'b1;
            bus.dm_we        = 1'b0;
            bus.dm_addr      = 32'h0000_5000;
            @(negedge clk);
            mon();
            if (bus.dm_req_ready) begin
                got_g[g] = 1'b1;
                g++;
            end else if (bus.if_req_ready) begin
                got_g[g] = 1'b0;
                g++;
            end
            n++;
        end
        chk("arb_grants", 32'(g), 32'd10);
        for (int i = 0; i < g; i++) chk($sformatf("arb_grant%0d", i), 32'(got_g[i]), 32'(exp_g[i]));
        tick();
        bus.if_req_valid = 1'b0;
        bus.dm_req_valid = 1'b0;
        @(negedge clk);
        mon();
        drain("arb_drain");

        // Stray memory response while idle.
        tick();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'hBAD0_BAD0;
        @(negedge clk);
        mon();
        chk("stray_if_rsp", 32'(bus.if_rsp_valid), 32'd0);
        chk("stray_dm_rsp", 32'(bus.dm_rsp_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            mon();
            chk($sformatf("perr_sticky%0d", i), 32'(protocol_err), 32'd1);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("perr_cleared", 32'(protocol_err), 32'd0);

        // Reset while waiting on memory: response dropped, late response flagged.
        mm_cnt     = 0;
        mm_rsp_lat = 3;
        tick();
        bus.dm_req_valid = 1'b1;
        bus.dm_we        = 1'b0;
        bus.dm_addr      = 32'h0000_0300;
        @(negedge clk);
        mon();
        tick();
        bus.dm_req_valid = 1'b0;
        @(negedge clk);
        mon();
        tick();
        @(negedge clk);
        mon();
        chk("wait_busy", 32'(busy), 32'd1);
        tick();
        rst              = 1'b1;
        bus.dm_req_valid = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("rstw_busy", 32'(busy), 32'd0);
        chk("rstw_dm_ready", 32'(bus.dm_req_ready), 32'd0);
        chk("rstw_if_ready", 32'(bus.if_req_ready), 32'd0);
        chk("rstw_mem_vld", 32'(bus.mem_req_valid), 32'd0);
        chk("rstw_dm_rsp", 32'(bus.dm_rsp_valid), 32'd0);
        sb.delete();
        tick();
        rst              = 1'b0;
        bus.dm_req_valid = 1'b0;
        @(negedge clk);
        mon();
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            mon();
        end
        chk("late_rsp_perr", 32'(protocol_err), 32'd1);
        mm_rsp_lat = 0;

        // Random traffic with random memory latency.
        tick();
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        mm_rand = 1'b1;
        mm_cnt  = 0;
        if_hold = 1'b0;
        dm_hold = 1'b0;
        for (int c = 0; c < 600; c++) begin
            tick();
            if (!if_hold) begin
                bus.if_req_valid = 1'($urandom_range(0, 1));
                bus.if_addr      = $urandom;
                if_hold          = bus.if_req_valid;
            end
            if (!dm_hold) begin
                bus.dm_req_valid = 1'($urandom_range(0, 1));
                bus.dm_we        = 1'($urandom_range(0, 1));
                bus.dm_addr      = $urandom;
                bus.dm_wdata     = $urandom;
                bus.dm_wstrb     = 4'($urandom_range(0, 15));
                dm_hold          = bus.dm_req_valid;
            end
            @(negedge clk);
            mon();
            if (bus.if_req_valid && bus.if_req_ready) if_hold = 1'b0;
            if (bus.dm_req_valid && bus.dm_req_ready) dm_hold = 1'b0;
        end
        tick();
        bus.if_req_valid = 1'b0;
        bus.dm_req_valid = 1'b0;
        @(negedge clk);
        mon();
        drain("rand_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
